serial_twos_deserializer: RTL and testbench
===========================================

# serial_twos_deserializer

Receive-side partner of the team's serial two's complementer. Accepts an LSB-first serial bit stream framed by a start-of-frame strobe and assembles each frame into a W-bit parallel word. Optionally applies serial two's-complement on the fly to undo a negation performed at the transmit end. Presents each completed word on a valid/ready output port toward downstream parallel logic.

## Interface
- W, default 8: frame/word width in bits, W ≥ 2.
- clk  input  1  rising-edge clock.
- rstn  input  1  reset, asynchronous, active-low.
- si  input  1  serial data bit, LSB first.
- bit_en  input  1  si is a valid bit this cycle; stream may stall with bit_en=0.
- sof  input  1  marks si as bit 0 of a new frame; ignored unless bit_en=1.
- out_data  output  W  assembled word.
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  downstream accepts out_data when out_valid=1.
- overrun  output  1  sticky: a completed frame was dropped because the output was full.
- abort  output  1  one-cycle pulse: sof arrived while a frame was partially received.

## Operation
- Reset values: out_data=0, out_valid=0, overrun=0, abort=0, state=IDLE, bit count=0, shift register=0, carry=1.
- States: IDLE (waiting for sof) and SHIFT (bits 1..W-1 pending).
- IDLE: bit_en=1 with sof=1 → capture bit 0, count=1, carry reinitialised, go to SHIFT. bit_en=1 with sof=0 → bit discarded, stay in IDLE.
- SHIFT: each bit_en=1 shifts the processed bit in at the MSB end; shift register := {b, sr[W-1:1]}; count increments. When bit W-1 is accepted, the word completes and the FSM returns to IDLE.
- sof=1 while in SHIFT: partial frame discarded, abort pulses, and the bit is taken as bit 0 of a new frame (count=1, carry reinitialised).
- Word completion with out_valid=0, or with out_valid=1 and out_ready=1 in the same cycle: load out_data, set out_valid=1.
- Word completion with out_valid=1 and out_ready=0: new word dropped, out_data unchanged, overrun set.
- out_valid=1 and out_ready=1 with no completion: clear out_valid; out_data retains its value.
- overrun clears only on rstn.
- Reset mid-frame: partial word lost; all state returns to reset values immediately.

## Timing
- Bit capture on the rising clk edge where bit_en=1.
- out_valid rises in the cycle after the edge that samples bit W-1. Latency from bit 0 to out_valid with no stalls: W cycles.
- Back-to-back frames: sof may accompany the bit immediately after bit W-1. Sustained throughput is one word per W cycles with no loss, provided out_ready=1 within W-1 cycles of out_valid.
- abort and overrun update on the same edge that causes them.

## Configuration
- Macro SERIAL_DESER_NEGATE_EN.
- Defined: each bit passes through a serial negate cell before entering the shift register.
  - sum = carry + !si; b = sum[0]; carry := sum[1].
  - carry is reinitialised to 1 at every sof.
  - out_data equals the two's complement (mod 2^W) of the received word.
- Undefined: b = si; no carry register; out_data equals the received word.

## Structure
- Package serial_pkg holds:
  - the FSM state enum (IDLE, SHIFT),
  - default width constant SERIAL_W=8,
  - carry reset constant NEG_CARRY_INIT=1'b1.
- One sub-module, serial_negate_cell: ports clk, rstn, init, en, si → bo. It is instantiated only under SERIAL_DESER_NEGATE_EN.

## Test plan
- Without macro, W=8: send 0x05 LSB-first, sof on bit 0, out_ready=1 → out_data=0x05, out_valid high 1 cycle, 8 cycles after bit 0.
- With macro: send 0x05 → out_data=0xFB. Send 0xFB → 0x05. Send 0x80 → 0x80. Send 0x00 → 0x00.
- Stalls: 0xA3 sent with bit_en low for 3 cycles between bits 2 and 3 → out_data=0xA3 (raw) / 0x5D (macro), latency 11 cycles.
- Abort: 4 bits of 0xFF, then sof with 0x12 → abort pulses once; only 0x12 (raw) / 0xEE (macro) is delivered.
- Overrun: out_ready=0, send 0x11 then 0x22 → out_data stays 0x11 (raw), overrun=1. Raising out_ready then clears out_valid; overrun stays 1.
- Reset: rstn low after 5 bits → all outputs 0. Next full frame 0x3C is received correctly (raw 0x3C / macro 0xC4).

Source files
------------

// File: rtl/serial_twos_deserializer_pkg.sv
// serial_pkg: shared types and constants for the serial deserializer slice.
// Used by serial_twos_deserializer and serial_negate_cell (SERIAL_DESER_NEGATE_EN).
package serial_pkg;

    localparam int   SERIAL_W       = 8;
    localparam logic NEG_CARRY_INIT = 1'b1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/serial_twos_deserializer_if.sv
// serial_twos_deserializer_if: serial input stream plus valid/ready word output.
// master drives the stream and out_ready; slave is the deserializer.
interface serial_twos_deserializer_if
    import serial_pkg::*;
#(
    parameter int W = SERIAL_W
);

    logic         si;
    logic         bit_en;
    logic         sof;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         overrun;
    logic         abort;

    modport master (
        output si, bit_en, sof, out_ready,
        input  out_data, out_valid, overrun, abort
    );

    modport slave (
        input  si, bit_en, sof, out_ready,
        output out_data, out_valid, overrun, abort
    );

endinterface

// File: rtl/serial_twos_deserializer_negate_cell.sv
// serial_negate_cell: bit-serial two's-complement cell (LSB first).
// b = (carry + !si)[0], carry := (carry + !si)[1]; init forces carry-in to 1
// for the current bit so a new frame starts cleanly on the same cycle.
// Only instantiated when SERIAL_DESER_NEGATE_EN is defined.
module serial_negate_cell
    import serial_pkg::*;
(
    input  logic clk,
    input  logic rstn,
    input  logic init,
    input  logic en,
    input  logic si,
    output logic bo
);

    logic       r_carry;
    logic       w_cin;
    logic [1:0] w_sum;

    assign w_cin = init ? NEG_CARRY_INIT : r_carry;
    assign w_sum = {1'b0, w_cin} + {1'b0, ~si};
    assign bo    = w_sum[0];

    // Carry advances only on bits that actually enter a frame.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_carry <= NEG_CARRY_INIT;
        end else if (en) begin
            r_carry <= w_sum[1];
        end
    end

endmodule

// File: rtl/serial_twos_deserializer.sv
// serial_twos_deserializer: LSB-first serial-to-parallel receiver with
// sof framing, valid/ready output, sticky overrun and abort pulse.
// Optional feature macro: SERIAL_DESER_NEGATE_EN (on-the-fly two's complement).
//
//   state | meaning
//   IDLE  | waiting for a bit with sof; non-sof bits are discarded
//   SHIFT | bits 1..W-1 of the current frame pending
module serial_twos_deserializer
    import serial_pkg::*;
#(
    parameter int W = SERIAL_W
)(
    input  logic                         clk,
    input  logic                         rstn,
    serial_twos_deserializer_if.slave    bus
);

    localparam int CNT_W = (W > 2) ? $clog2(W) : 1;

    state_t         r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [W-1:0]   r_sr;
    logic [W-1:0]   r_out_data;
    logic           r_out_valid;
    logic           r_overrun;
    logic           r_abort;

    logic           w_bit;
    logic           w_take;
    logic           w_cnt_last;
    logic           w_done;
    logic [W-1:0]   w_word;

    // A bit belongs to a frame when it starts one or arrives mid-frame.
    assign w_take = bus.bit_en && (bus.sof || (r_state == SHIFT));

`ifdef SERIAL_DESER_NEGATE_EN
    serial_negate_cell u_negate (
        .clk  (clk),
        .rstn (rstn),
        .init (bus.sof),
        .en   (w_take),
        .si   (bus.si),
        .bo   (w_bit)
    );
`else
    assign w_bit = bus.si;
`endif

    assign w_cnt_last = (r_cnt == CNT_W'(W - 1));
    assign w_done     = bus.bit_en && !bus.sof && (r_state == SHIFT) && w_cnt_last;
    assign w_word     = {w_bit, r_sr[W-1:1]};

    // Frame FSM, shift register and registered output port in one process.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_sr        <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
            r_abort     <= 1'b0;
        end else begin
            r_abort <= 1'b0;

            if (bus.bit_en) begin
                if (bus.sof) begin
                    // Bit 0 parks at the MSB; W-1 further shifts bring it to bit 0.
                    r_sr    <= {w_bit, {(W-1){1'b0}}};
                    r_cnt   <= CNT_W'(1);
                    r_state <= SHIFT;
                    if (r_state == SHIFT) begin
                        r_abort <= 1'b1;
                    end
                end else if (r_state == SHIFT) begin
                    r_sr <= w_word;
                    if (w_cnt_last) begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
            end

            if (w_done) begin
                if (!r_out_valid || bus.out_ready) begin
                    r_out_data  <= w_word;
                    r_out_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign bus.overrun   = r_overrun;
    assign bus.abort     = r_abort;

endmodule

// File: tb/tb_serial_twos_deserializer.sv
// tb_serial_twos_deserializer: directed bench for serial_twos_deserializer (W=8).
// Expected words follow SERIAL_DESER_NEGATE_EN when defined.
module tb_serial_twos_deserializer;

`ifdef SERIAL_DESER_NEGATE_EN
    localparam logic [7:0] E05 = 8'hFB;
    localparam logic [7:0] EFB = 8'h05;
    localparam logic [7:0] E80 = 8'h80;
    localparam logic [7:0] E00 = 8'h00;
    localparam logic [7:0] EA3 = 8'h5D;
    localparam logic [7:0] E12 = 8'hEE;
    localparam logic [7:0] E11 = 8'hEF;
    localparam logic [7:0] E3C = 8'hC4;
`else
    localparam logic [7:0] E05 = 8'h05;
    localparam logic [7:0] EFB = 8'hFB;
    localparam logic [7:0] E80 = 8'h80;
    localparam logic [7:0] E00 = 8'h00;
    localparam logic [7:0] EA3 = 8'hA3;
    localparam logic [7:0] E12 = 8'h12;
    localparam logic [7:0] E11 = 8'h11;
    localparam logic [7:0] E3C = 8'h3C;
`endif

    logic clk;
    logic rstn;
    int   cyc;
    int   checks;
    int   errors;

    serial_twos_deserializer_if #(.W(8)) u_if ();

    serial_twos_deserializer #(.W(8)) u_dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends one LSB-first frame; stall_n idle cycles are inserted between bits 2 and 3.
    task automatic send_frame(input logic [7:0] val, input int stall_n,
                              output logic ab0, output logic ab1,
                              output logic pre_v, output int lat);
        int t0;
        t0    = cyc;
        ab0   = 1'b0;
        ab1   = 1'b0;
        pre_v = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                for (int s = 0; s < stall_n; s++) begin
                    u_if.bit_en = 1'b0;
                    u_if.sof    = 1'b0;
                    tick();
                end
            end
            u_if.si     = val[i];
            u_if.bit_en = 1'b1;
            u_if.sof    = (i == 0);
            if (i == 7) pre_v = u_if.out_valid;
            tick();
            if (i == 0) ab0 = u_if.abort;
            if (i == 1) ab1 = u_if.abort;
        end
        u_if.bit_en = 1'b0;
        u_if.sof    = 1'b0;
        lat = cyc - t0;
    endtask

    initial begin
        logic a0, a1, pv;
        int   lat;
        logic [7:0] pat;

        checks = 0;
        errors = 0;
        cyc    = 0;
        rstn   = 1'b0;
        u_if.si        = 1'b0;
        u_if.bit_en    = 1'b0;
        u_if.sof       = 1'b0;
        u_if.out_ready = 1'b1;

        #1;
        check("rst_data",    {24'd0, u_if.out_data}, 32'h0);
        check("rst_valid",   {31'd0, u_if.out_valid}, 32'h0);
        check("rst_overrun", {31'd0, u_if.overrun}, 32'h0);
        check("rst_abort",   {31'd0, u_if.abort}, 32'h0);
        tick();
        tick();
        rstn = 1'b1;
        tick();

        // Single frame 0x05, no stalls.
        send_frame(8'h05, 0, a0, a1, pv, lat);
        check("f05_data",    {24'd0, u_if.out_data}, {24'd0, E05});
        check("f05_valid",   {31'd0, u_if.out_valid}, 32'h1);
        check("f05_latency", lat, 8);
        check("f05_prevalid", {31'd0, pv}, 32'h0);
        tick();
        check("f05_valid_drop", {31'd0, u_if.out_valid}, 32'h0);

        // Bits without sof in IDLE are discarded.
        for (int i = 0; i < 3; i++) begin
            u_if.si     = 1'b1;
            u_if.bit_en = 1'b1;
            u_if.sof    = 1'b0;
            tick();
        end
        u_if.bit_en = 1'b0;
        tick();
        check("idle_discard_valid", {31'd0, u_if.out_valid}, 32'h0);

        // Back-to-back frames.
        send_frame(8'hFB, 0, a0, a1, pv, lat);
        check("fFB_data", {24'd0, u_if.out_data}, {24'd0, EFB});
        send_frame(8'h80, 0, a0, a1, pv, lat);
        check("f80_data", {24'd0, u_if.out_data}, {24'd0, E80});
        check("f80_valid", {31'd0, u_if.out_valid}, 32'h1);
        send_frame(8'h00, 0, a0, a1, pv, lat);
        check("f00_data", {24'd0, u_if.out_data}, {24'd0, E00});
        tick();

        // Stalled frame 0xA3.
        send_frame(8'hA3, 3, a0, a1, pv, lat);
        check("fA3_data",    {24'd0, u_if.out_data}, {24'd0, EA3});
        check("fA3_latency", lat, 11);
        tick();

        // Abort: 4 bits of 0xFF, then a fresh frame 0x12.
        pat = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            u_if.si     = pat[i];
            u_if.bit_en = 1'b1;
            u_if.sof    = (i == 0);
            tick();
        end
        check("abort_idle", {31'd0, u_if.abort}, 32'h0);
        send_frame(8'h12, 0, a0, a1, pv, lat);
        check("abort_pulse",   {31'd0, a0}, 32'h1);
        check("abort_cleared", {31'd0, a1}, 32'h0);
        check("abort_noearly", {31'd0, pv}, 32'h0);
        check("f12_data",      {24'd0, u_if.out_data}, {24'd0, E12});
        tick();

        // Overrun with out_ready low.
        u_if.out_ready = 1'b0;
        send_frame(8'h11, 0, a0, a1, pv, lat);
        check("f11_data",  {24'd0, u_if.out_data}, {24'd0, E11});
        check("f11_valid", {31'd0, u_if.out_valid}, 32'h1);
        check("f11_no_overrun", {31'd0, u_if.overrun}, 32'h0);
        send_frame(8'h22, 0, a0, a1, pv, lat);
        check("ovr_data_kept", {24'd0, u_if.out_data}, {24'd0, E11});
        check("ovr_set",       {31'd0, u_if.overrun}, 32'h1);
        u_if.out_ready = 1'b1;
        tick();
        check("ovr_valid_clr", {31'd0, u_if.out_valid}, 32'h0);
        check("ovr_sticky",    {31'd0, u_if.overrun}, 32'h1);
        check("ovr_data_hold", {24'd0, u_if.out_data}, {24'd0, E11});

        // Reset mid-frame after 5 bits.
        pat = 8'h77;
        for (int i = 0; i < 5; i++) begin
            u_if.si     = pat[i];
            u_if.bit_en = 1'b1;
            u_if.sof    = (i == 0);
            tick();
        end
        u_if.bit_en = 1'b0;
        u_if.sof    = 1'b0;
        rstn = 1'b0;
        #1;
        check("mrst_data",    {24'd0, u_if.out_data}, 32'h0);
        check("mrst_valid",   {31'd0, u_if.out_valid}, 32'h0);
        check("mrst_overrun", {31'd0, u_if.overrun}, 32'h0);
        check("mrst_abort",   {31'd0, u_if.abort}, 32'h0);
        tick();
        rstn = 1'b1;
        tick();
        send_frame(8'h3C, 0, a0, a1, pv, lat);
        check("f3C_data",    {24'd0, u_if.out_data}, {24'd0, E3C});
        check("f3C_valid",   {31'd0, u_if.out_valid}, 32'h1);
        check("f3C_latency", lat, 8);
        check("f3C_noabort", {31'd0, a0}, 32'h0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
